trap_ctrl: RTL and testbench

//  Consumes the decoder's exception/return requests (exc_en/exc_code/exc_val, mret) and sequences M-mode trap entry and exit.

---
 rtl/trap_ctrl_if.sv | 33 +++
 rtl/trap_ctrl.sv | 153 +++++++++++++++
 tb/tb_trap_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Decoder/CSR-file/fetch side signals of the trap controller.
interface trap_ctrl_if #(
   parameter int unsigned XLEN = 64
);
   logic            exc_en;
   logic [3:0]      exc_code;
   logic [XLEN-1:0] exc_val;
   logic            mret;
   logic [XLEN-1:0] pc_addr;
   logic [XLEN-1:0] mstatus_i;
   logic [XLEN-1:0] mtvec_i;
   logic [XLEN-1:0] mepc_i;
   logic            trap_csr_we;
   logic [11:0]     trap_csr_addr;
   logic [XLEN-1:0] trap_csr_wdata;
   logic            pc_redirect;
   logic [XLEN-1:0] pc_redirect_tgt;
   logic            trap_taken;
   logic            trap_done;
   logic [1:0]      priv_lvl;

   modport master (
      output exc_en, exc_code, exc_val, mret, pc_addr, mstatus_i, mtvec_i, mepc_i,
      input  trap_csr_we, trap_csr_addr, trap_csr_wdata, pc_redirect, pc_redirect_tgt,
             trap_taken, trap_done, priv_lvl
   );

   modport slave (
      input  exc_en, exc_code, exc_val, mret, pc_addr, mstatus_i, mtvec_i, mepc_i,
      output trap_csr_we, trap_csr_addr, trap_csr_wdata, pc_redirect, pc_redirect_tgt,
             trap_taken, trap_done, priv_lvl
   );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap entry/exit sequencer: writes trap CSRs one per cycle, then redirects fetch.
// Owns the current privilege level.
module trap_ctrl #(
   parameter int unsigned XLEN       = 64,
   parameter logic [1:0]  RESET_PRIV = 2'b11
) (
   input  logic        clk,
   input  logic        rst_n,
   trap_ctrl_if.slave  bus
);
   localparam logic [11:0]     CSR_MSTATUS = 12'h300;
   localparam logic [11:0]     CSR_MEPC    = 12'h341;
   localparam logic [11:0]     CSR_MCAUSE  = 12'h342;
   localparam logic [11:0]     CSR_MTVAL   = 12'h343;
   localparam logic [1:0]      PRIV_M      = 2'b11;
   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

   typedef enum logic [2:0] {
      IDLE, E_EPC, E_CAUSE, E_TVAL, E_STATUS, E_REDIR, X_STATUS, X_REDIR
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] cap_pc_q, cap_pc_d;
   logic [XLEN-1:0] cap_val_q, cap_val_d;
   logic [3:0]      cap_code_q, cap_code_d;
   logic [1:0]      cap_priv_q, cap_priv_d;
   logic [1:0]      mpp_q, mpp_d;
   logic [1:0]      priv_q, priv_d;

   logic            csr_we;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic            redir;
   logic [XLEN-1:0] redir_tgt;

   // State and capture registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cap_pc_q   <= '0;
         cap_val_q  <= '0;
         cap_code_q <= '0;
         cap_priv_q <= '0;
         mpp_q      <= '0;
         priv_q     <= RESET_PRIV;
      end else begin
         state_q    <= state_d;
         cap_pc_q   <= cap_pc_d;
         cap_val_q  <= cap_val_d;
         cap_code_q <= cap_code_d;
         cap_priv_q <= cap_priv_d;
         mpp_q      <= mpp_d;
         priv_q     <= priv_d;
      end
   end

   // Next state, captures and CSR/redirect outputs
   always_comb begin
      state_d    = state_q;
      cap_pc_d   = cap_pc_q;
      cap_val_d  = cap_val_q;
      cap_code_d = cap_code_q;
      cap_priv_d = cap_priv_q;
      mpp_d      = mpp_q;
      priv_d     = priv_q;
      csr_we     = 1'b0;
      csr_addr   = '0;
      csr_wdata  = '0;
      redir      = 1'b0;
      redir_tgt  = '0;

      case (state_q)
         IDLE: begin
            if (bus.exc_en) begin
               cap_pc_d   = bus.pc_addr;
               cap_code_d = bus.exc_code;
               cap_val_d  = bus.exc_val;
               cap_priv_d = priv_q;
               state_d    = E_EPC;
            end else if (bus.mret && priv_q == PRIV_M) begin
               state_d    = X_STATUS;
            end else if (bus.mret) begin
               // MRET below M-mode is an illegal instruction
               cap_pc_d   = bus.pc_addr;
               cap_code_d = 4'd2;
               cap_val_d  = '0;
               cap_priv_d = priv_q;
               state_d    = E_EPC;
            end
         end
         E_EPC: begin
            csr_we    = 1'b1;
            csr_addr  = CSR_MEPC;
            csr_wdata = cap_pc_q & ALIGN_MASK;
            state_d   = E_CAUSE;
         end
         E_CAUSE: begin
            csr_we    = 1'b1;
            csr_addr  = CSR_MCAUSE;
            csr_wdata = XLEN'(cap_code_q);
            state_d   = E_TVAL;
         end
         E_TVAL: begin
            csr_we    = 1'b1;
            csr_addr  = CSR_MTVAL;
            csr_wdata = cap_val_q;
            state_d   = E_STATUS;
         end
         E_STATUS: begin
            csr_we           = 1'b1;
            csr_addr         = CSR_MSTATUS;
            csr_wdata        = bus.mstatus_i;
            csr_wdata[7]     = bus.mstatus_i[3];
            csr_wdata[3]     = 1'b0;
            csr_wdata[12:11] = cap_priv_q;
            state_d          = E_REDIR;
         end
         E_REDIR: begin
            redir     = 1'b1;
            redir_tgt = bus.mtvec_i & ALIGN_MASK;
            priv_d    = PRIV_M;
            state_d   = IDLE;
         end
         X_STATUS: begin
            csr_we           = 1'b1;
            csr_addr         = CSR_MSTATUS;
            csr_wdata        = bus.mstatus_i;
            csr_wdata[3]     = bus.mstatus_i[7];
            csr_wdata[7]     = 1'b1;
            csr_wdata[12:11] = 2'b00;
            mpp_d            = bus.mstatus_i[12:11];
            state_d          = X_REDIR;
         end
         X_REDIR: begin
            redir     = 1'b1;
            redir_tgt = bus.mepc_i & ALIGN_MASK;
            // Reserved MPP encoding falls back to U-mode
            priv_d    = (mpp_q == 2'b10) ? 2'b00 : mpp_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.trap_csr_we     = csr_we;
   assign bus.trap_csr_addr   = csr_addr;
   assign bus.trap_csr_wdata  = csr_wdata;
   assign bus.pc_redirect     = redir;
   assign bus.pc_redirect_tgt = redir_tgt;
   assign bus.trap_taken      = (state_q inside {E_EPC, E_CAUSE, E_TVAL, E_STATUS, E_REDIR});
   assign bus.trap_done       = (state_q inside {X_STATUS, X_REDIR});
   assign bus.priv_lvl        = priv_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected CSR writes and redirects are queued at request time.
module tb_trap_ctrl;
   localparam int unsigned XLEN = 64;

   typedef struct {
      bit          redir;
      int          cyc;
      logic [11:0] addr;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   logic [1:0] model_priv = 2'b11;
   exp_t sb[$];

   trap_ctrl_if #(.XLEN(XLEN)) bus ();

   trap_ctrl #(.XLEN(XLEN), .RESET_PRIV(2'b11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pop and compare whenever the DUT writes a CSR or redirects
   always @(negedge clk) begin
      exp_t e;
      if (bus.trap_csr_we === 1'b1) begin
         if (sb.size() == 0) check("csr_unexpected", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            check("csr_kind", 64'(e.redir), 64'd0);
            check("csr_cycle", 64'(cyc), 64'(e.cyc));
            check("csr_addr", 64'(bus.trap_csr_addr), 64'(e.addr));
            check("csr_data", bus.trap_csr_wdata, e.data);
         end
      end
      if (bus.pc_redirect === 1'b1) begin
         if (sb.size() == 0) check("redir_unexpected", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            check("redir_kind", 64'(e.redir), 64'd1);
            check("redir_cycle", 64'(cyc), 64'(e.cyc));
            check("redir_tgt", bus.pc_redirect_tgt, e.data);
         end
      end
   end

   task automatic push(input bit redir, input int c, input int k, input int rst_at,
                       input logic [11:0] addr, input logic [63:0] data);
      exp_t e;
      if (rst_at == 0 || k <= rst_at) begin
         e.redir = redir;
         e.cyc   = c + k;
         e.addr  = addr;
         e.data  = data;
         sb.push_back(e);
      end
   endtask

   // Drive one request in IDLE, queue the expected traffic, and follow the sequence
   task automatic run_req(input logic e, input logic m, input logic [3:0] code,
                          input logic [63:0] val, input logic [63:0] pc,
                          input logic [63:0] ms, input logic [63:0] tvec,
                          input logic [63:0] epc, input int rst_at, input bit poke);
      int          c;
      int          len;
      bit          entry;
      logic [1:0]  p0;
      logic [1:0]  exp_p;
      logic [3:0]  ecode;
      logic [63:0] eval;
      logic [63:0] st;
      p0    = model_priv;
      c     = cyc;
      entry = e || (m && p0 != 2'b11);
      if (entry) begin
         ecode = e ? code : 4'd2;
         eval  = e ? val : 64'd0;
         st = ms; st[7] = ms[3]; st[3] = 1'b0; st[12:11] = p0;
         push(1'b0, c, 1, rst_at, 12'h341, pc & ~64'h3);
         push(1'b0, c, 2, rst_at, 12'h342, {60'd0, ecode});
         push(1'b0, c, 3, rst_at, 12'h343, eval);
         push(1'b0, c, 4, rst_at, 12'h300, st);
         push(1'b1, c, 5, rst_at, 12'h000, tvec & ~64'h3);
         len   = 5;
         exp_p = 2'b11;
      end else begin
         st = ms; st[3] = ms[7]; st[7] = 1'b1; st[12:11] = 2'b00;
         push(1'b0, c, 1, rst_at, 12'h300, st);
         push(1'b1, c, 2, rst_at, 12'h000, epc & ~64'h3);
         len   = 2;
         exp_p = (ms[12:11] == 2'b10) ? 2'b00 : ms[12:11];
      end
      if (rst_at > 0) begin
         len   = rst_at;
         exp_p = 2'b11;
      end

      bus.exc_en    = e;
      bus.mret      = m;
      bus.exc_code  = code;
      bus.exc_val   = val;
      bus.pc_addr   = pc;
      bus.mstatus_i = ms;
      bus.mtvec_i   = tvec;
      bus.mepc_i    = epc;
      @(negedge clk);
      bus.exc_en = 1'b0;
      bus.mret   = 1'b0;
      for (int k = 1; k <= len; k++) begin
         check(entry ? "trap_taken_seq" : "trap_done_seq",
               64'(entry ? bus.trap_taken : bus.trap_done), 64'd1);
         check(entry ? "trap_done_seq" : "trap_taken_seq",
               64'(entry ? bus.trap_done : bus.trap_taken), 64'd0);
         if (poke && k == 2) begin
            bus.exc_en = 1'b1;
            bus.mret   = 1'b1;
         end
         if (poke && k == 3) begin
            bus.exc_en = 1'b0;
            bus.mret   = 1'b0;
         end
         if (rst_at == k) rst_n = 1'b0;
         @(negedge clk);
      end
      rst_n = 1'b1;
      check("idle_taken", 64'(bus.trap_taken), 64'd0);
      check("idle_done", 64'(bus.trap_done), 64'd0);
      check("idle_we", 64'(bus.trap_csr_we), 64'd0);
      check("idle_addr", 64'(bus.trap_csr_addr), 64'd0);
      check("idle_redir", 64'(bus.pc_redirect), 64'd0);
      check("priv_after", 64'(bus.priv_lvl), 64'(exp_p));
      model_priv = exp_p;
   endtask

   initial begin
      bus.exc_en    = 1'b0;
      bus.mret      = 1'b0;
      bus.exc_code  = '0;
      bus.exc_val   = '0;
      bus.pc_addr   = '0;
      bus.mstatus_i = '0;
      bus.mtvec_i   = '0;
      bus.mepc_i    = '0;
      repeat (2) @(negedge clk);
      check("rst_taken", 64'(bus.trap_taken), 64'd0);
      check("rst_done", 64'(bus.trap_done), 64'd0);
      check("rst_we", 64'(bus.trap_csr_we), 64'd0);
      check("rst_wdata", bus.trap_csr_wdata, 64'd0);
      check("rst_redir", 64'(bus.pc_redirect), 64'd0);
      check("rst_tgt", bus.pc_redirect_tgt, 64'd0);
      check("rst_priv", 64'(bus.priv_lvl), 64'd3);
      rst_n = 1'b1;
      @(negedge clk);

      // MRET from M with MPP=M
      run_req(1'b0, 1'b1, 4'd0, 64'd0, 64'h0, 64'h1880, 64'h0, 64'h2004, 0, 1'b0);
      // MRET to U
      run_req(1'b0, 1'b1, 4'd0, 64'd0, 64'h0, 64'h0080, 64'h0, 64'h1000, 0, 1'b0);
      // ECALL from U
      run_req(1'b1, 1'b0, 4'd8, 64'd0, 64'h1000, 64'h0008, 64'h8000_0001, 64'h0, 0, 1'b0);
      // back to U, MPIE clear
      run_req(1'b0, 1'b1, 4'd0, 64'd0, 64'h0, 64'h0000, 64'h0, 64'h1002, 0, 1'b0);
      // MRET in U mode is illegal
      run_req(1'b0, 1'b1, 4'd5, 64'h77, 64'h3002, 64'h0088, 64'h9000_0003, 64'h0, 0, 1'b0);
      // exc_en + mret together, plus a late request during E_CAUSE
      run_req(1'b1, 1'b1, 4'd3, 64'hdead, 64'h4000, 64'h1888, 64'h100, 64'h0, 0, 1'b1);
      // reserved MPP=10 maps to U
      run_req(1'b0, 1'b1, 4'd0, 64'd0, 64'h0, 64'h1080, 64'h0, 64'h5555, 0, 1'b0);
      // reset during E_TVAL
      run_req(1'b1, 1'b0, 4'd8, 64'h55, 64'h5000, 64'h0008, 64'h200, 64'h0, 3, 1'b0);
      // MRET to S, then ECALL from S
      run_req(1'b0, 1'b1, 4'd0, 64'd0, 64'h0, 64'h0880, 64'h0, 64'h6000, 0, 1'b0);
      run_req(1'b1, 1'b0, 4'd9, 64'h1234, 64'h6008, 64'h000a, 64'h4000_0002, 64'h0, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
